// File: rtl/freq_pulse_generator.sv
// Programmable square-wave and pulse-burst source for the frequency counter.
// Config is taken only in IDLE; freq_out, done and cfg_err come straight from flops.
module freq_pulse_generator #(
    parameter int CLK_HZ  = 50000000,
    parameter int DIV_W   = 24,
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DIV_W-1:0]   cfg_half_period,
    input  logic [BURST_W-1:0] cfg_burst_len,
    input  logic               start,
    input  logic               stop,
    output logic               freq_out,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulse_count,
    output logic               cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   half_q, half_d;
    logic [DIV_W-1:0]   phase_q, phase_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] count_q, count_d;
    logic               loaded_q, loaded_d;
    logic               out_q, out_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               phase_end;
    logic               burst_last;

    if (CLK_HZ < 2) begin : g_clk_check
        $error("CLK_HZ must be at least 2");
    end

    assign phase_end  = (phase_q == half_q - DIV_W'(1));
    assign burst_last = (burst_q != '0) && (count_q == burst_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            half_q   <= '0;
            phase_q  <= '0;
            burst_q  <= '0;
            count_q  <= '0;
            loaded_q <= 1'b0;
            out_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            phase_q  <= phase_d;
            burst_q  <= burst_d;
            count_q  <= count_d;
            loaded_q <= loaded_d;
            out_q    <= out_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // A stop during a high phase lets that phase run to full length (STOPPING),
    // so no runt pulse escapes; a burst end on the same edge still reports done.
    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        phase_d  = phase_q;
        burst_d  = burst_q;
        count_d  = count_q;
        loaded_d = loaded_q;
        out_d    = out_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (cfg_half_period == '0) begin
                        err_d = 1'b1;
                    end else begin
                        half_d   = cfg_half_period;
                        burst_d  = cfg_burst_len;
                        loaded_d = 1'b1;
                    end
                end
                if (start && !stop) begin
                    if (loaded_q) begin
                        state_d = RUN;
                        out_d   = 1'b1;
                        phase_d = '0;
                        count_d = BURST_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (phase_end) begin
                    phase_d = '0;
                    if (out_q) begin
                        out_d = 1'b0;
                        if (burst_last) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else if (stop) begin
                            state_d = IDLE;
                        end
                    end else if (stop) begin
                        state_d = IDLE;
                    end else begin
                        out_d   = 1'b1;
                        count_d = count_q + BURST_W'(1);
                    end
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                    if (stop) begin
                        state_d = out_q ? STOPPING : IDLE;
                    end
                end
            end

            STOPPING: begin
                if (phase_end) begin
                    phase_d = '0;
                    out_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                out_d   = 1'b0;
            end
        endcase
    end

    assign cfg_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign freq_out    = out_q;
    assign done        = done_q;
    assign cfg_err     = err_q;
    assign pulse_count = count_q;

endmodule

// File: tb/tb_freq_pulse_generator.sv
// Directed bench for freq_pulse_generator: an offset-arithmetic waveform model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_freq_pulse_generator;

    localparam int CLK_HZ  = 50000000;
    localparam int DIV_W   = 24;
    localparam int BURST_W = 16;
    localparam longint NEVER = 64'h3fff_ffff_ffff_ffff;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [DIV_W-1:0]   cfg_half_period;
    logic [BURST_W-1:0] cfg_burst_len;
    logic               start;
    logic               stop;
    logic               freq_out;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] pulse_count;
    logic               cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    freq_pulse_generator #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W),
        .BURST_W(BURST_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_half_period(cfg_half_period),
        .cfg_burst_len  (cfg_burst_len),
        .start          (start),
        .stop           (stop),
        .freq_out       (freq_out),
        .busy           (busy),
        .done           (done),
        .pulse_count    (pulse_count),
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // Model: a run is described by its start cycle; the waveform at offset t is
    // high when (t / half) is even, and the run ends at a precomputed offset.
    bit     model_valid = 1'b0;
    longint cyc = 0;
    bit     m_run = 0, m_loaded = 0, m_out = 0, m_done = 0, m_err = 0, m_stopped = 0;
    longint m_sh = 0, m_sb = 0, m_h = 1, m_start = 0, m_end = NEVER, m_bend = -1;
    int     m_cnt = 0;

    always @(posedge clk) begin : model
        longint t, p;
        bit was_loaded;
        cyc++;
        model_valid = 1'b1;
        if (rst) begin
            m_run = 0; m_loaded = 0; m_out = 0; m_done = 0; m_err = 0;
            m_cnt = 0; m_sh = 0; m_sb = 0;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (m_run) begin
                t = cyc - m_start;
                p = t - 1;
                if (stop && !m_stopped && t != m_end) begin
                    m_stopped = 1;
                    if (((p / m_h) % 2) == 0) m_end = (p / m_h + 1) * m_h;
                    else                      m_end = t;
                end
                if (t >= m_end) begin
                    m_run  = 0;
                    m_out  = 0;
                    m_done = (t == m_bend) && !m_stopped;
                end else begin
                    m_out = ((t / m_h) % 2) == 0;
                    m_cnt = int'((t / (2 * m_h) + 1) % 65536);
                end
            end else begin
                was_loaded = m_loaded;
                if (cfg_valid) begin
                    if (cfg_half_period == '0) m_err = 1;
                    else begin
                        m_sh = longint'(cfg_half_period);
                        m_sb = longint'(cfg_burst_len);
                        m_loaded = 1;
                    end
                end
                if (start && !stop) begin
                    if (was_loaded) begin
                        m_run = 1; m_start = cyc; m_h = m_sh; m_out = 1; m_cnt = 1; m_stopped = 0;
                        m_bend = (m_sb == 0) ? -1 : (2 * m_sb - 1) * m_sh;
                        m_end  = (m_sb == 0) ? NEVER : m_bend;
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("freq_out", 32'(freq_out), 32'(m_out));
            checkOutput("busy", 32'(busy), 32'(m_run));
            checkOutput("cfg_ready", 32'(cfg_ready), 32'(!m_run));
            checkOutput("done", 32'(done), 32'(m_done));
            checkOutput("cfg_err", 32'(cfg_err), 32'(m_err));
            checkOutput("pulse_count", 32'(pulse_count), 32'(m_cnt));
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of inputs, lets the next edge sample them, then idles them.
    task automatic applyStimulus(input logic cv, input int half, input int burst,
                                 input logic st, input logic sp);
        cfg_valid       = cv;
        cfg_half_period = DIV_W'(half);
        cfg_burst_len   = BURST_W'(burst);
        start           = st;
        stop            = sp;
        stepCycle();
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int rises[$];
        int guard;
        logic prev;

        rst = 1'b1; cfg_valid = 1'b0; cfg_half_period = '0; cfg_burst_len = '0;
        start = 1'b0; stop = 1'b0;
        repeat (2) stepCycle();
        rst = 1'b0;
        repeat (20) stepCycle();
        checkOutput("idle freq_out", 32'(freq_out), 0);
        checkOutput("idle busy", 32'(busy), 0);
        checkOutput("idle cfg_ready", 32'(cfg_ready), 1);
        checkOutput("idle pulse_count", 32'(pulse_count), 0);

        $display("[TB] start without config");
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("unloaded start cfg_err", 32'(cfg_err), 1);
        checkOutput("unloaded start busy", 32'(busy), 0);
        stepCycle();
        checkOutput("cfg_err one cycle", 32'(cfg_err), 0);

        $display("[TB] zero half-period config");
        applyStimulus(1, 0, 7, 0, 0);
        checkOutput("zero half cfg_err", 32'(cfg_err), 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("still unloaded cfg_err", 32'(cfg_err), 1);
        checkOutput("still unloaded busy", 32'(busy), 0);

        $display("[TB] burst half=5 len=3");
        applyStimulus(1, 5, 3, 0, 0);
        checkOutput("cfg accepted no err", 32'(cfg_err), 0);
        applyStimulus(0, 0, 0, 1, 0);
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) stepCycle();
            case (k)
                0:  begin checkOutput("E0 freq_out", 32'(freq_out), 1); checkOutput("E0 pc", 32'(pulse_count), 1); end
                4:  checkOutput("E4 freq_out", 32'(freq_out), 1);
                5:  checkOutput("E5 freq_out", 32'(freq_out), 0);
                10: begin checkOutput("E10 freq_out", 32'(freq_out), 1); checkOutput("E10 pc", 32'(pulse_count), 2); end
                20: checkOutput("E20 pc", 32'(pulse_count), 3);
                24: begin checkOutput("E24 freq_out", 32'(freq_out), 1); checkOutput("E24 done", 32'(done), 0); end
                25: begin checkOutput("E25 freq_out", 32'(freq_out), 0); checkOutput("E25 done", 32'(done), 1);
                          checkOutput("E25 pc", 32'(pulse_count), 3); end
                26: begin checkOutput("E26 busy", 32'(busy), 0); checkOutput("E26 done", 32'(done), 0); end
                30: checkOutput("E30 pc hold", 32'(pulse_count), 3);
                default: ;
            endcase
        end

        $display("[TB] stop coinciding with burst end");
        applyStimulus(1, 2, 2, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        repeat (5) stepCycle();
        stop = 1'b1;
        stepCycle();
        stop = 1'b0;
        checkOutput("stop+end done", 32'(done), 1);
        checkOutput("stop+end pc", 32'(pulse_count), 2);

        $display("[TB] busy protection");
        applyStimulus(1, 3, 4, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        repeat (3) stepCycle();
        cfg_valid = 1'b1; cfg_half_period = DIV_W'(9); cfg_burst_len = BURST_W'(1);
        for (int k = 4; k <= 21; k++) begin
            start = (k == 8) || (k == 14);
            stepCycle();
            if (k == 10) checkOutput("run cfg_ready", 32'(cfg_ready), 0);
        end
        start = 1'b0;
        checkOutput("protected pc", 32'(pulse_count), 4);
        checkOutput("protected busy", 32'(busy), 0);
        guard = 0;
        while (!cfg_ready && guard < 50) begin stepCycle(); guard++; end
        checkOutput("cfg_ready returned", 32'(cfg_ready), 1);
        stepCycle();
        cfg_valid = 1'b0;
        applyStimulus(0, 0, 0, 1, 0);
        repeat (8) stepCycle();
        checkOutput("new half k8 high", 32'(freq_out), 1);
        stepCycle();
        checkOutput("new half k9 low", 32'(freq_out), 0);
        checkOutput("new burst done", 32'(done), 1);

        $display("[TB] continuous half=2 with stop in high phase");
        applyStimulus(1, 2, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        rises.delete();
        rises.push_back(0);
        prev = freq_out;
        for (int k = 1; k <= 12; k++) begin
            stepCycle();
            if (freq_out && !prev) rises.push_back(k);
            prev = freq_out;
        end
        checkOutput("rise count", 32'(rises.size()), 4);
        if (rises.size() >= 2) checkOutput("period", 32'(rises[1] - rises[0]), 4);
        stop = 1'b1;
        stepCycle();
        stop = 1'b0;
        checkOutput("stopping still high", 32'(freq_out), 1);
        checkOutput("stopping busy", 32'(busy), 1);
        stepCycle();
        checkOutput("stopped low", 32'(freq_out), 0);
        checkOutput("stopped busy", 32'(busy), 0);
        checkOutput("stopped pc", 32'(pulse_count), 4);

        $display("[TB] stop in low phase");
        applyStimulus(1, 4, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        repeat (5) stepCycle();
        stop = 1'b1;
        stepCycle();
        stop = 1'b0;
        checkOutput("low stop busy", 32'(busy), 0);
        checkOutput("low stop pc", 32'(pulse_count), 1);
        repeat (3) stepCycle();
        checkOutput("low stop no rise", 32'(freq_out), 0);

        $display("[TB] start and stop together in idle");
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("start+stop busy", 32'(busy), 0);
        checkOutput("start+stop cfg_err", 32'(cfg_err), 0);

        $display("[TB] single pulse half=1");
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("half1 k0", 32'(freq_out), 1);
        stepCycle();
        checkOutput("half1 k1", 32'(freq_out), 0);
        checkOutput("half1 done", 32'(done), 1);

        $display("[TB] loopback rate half=25 then reset mid-run");
        applyStimulus(1, 25, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        rises.delete();
        rises.push_back(0);
        prev = freq_out;
        for (int k = 1; k <= 110; k++) begin
            stepCycle();
            if (freq_out && !prev) rises.push_back(k);
            prev = freq_out;
        end
        checkOutput("loopback rises", 32'(rises.size()), 3);
        if (rises.size() >= 3)
            checkOutput("loopback Hz", 32'(CLK_HZ / (rises[2] - rises[1])), 1000000);
        checkOutput("pre-reset high", 32'(freq_out), 1);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("reset freq_out", 32'(freq_out), 0);
        checkOutput("reset done", 32'(done), 0);
        checkOutput("reset pc", 32'(pulse_count), 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("config cleared by reset", 32'(cfg_err), 1);

        repeat (3) stepCycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_pulse_generator.md
Name: freq_pulse_generator

Overview:
- Programmable square-wave and pulse-burst source. It is the stimulus side of the digital frequency counter: it drives a known frequency or a known pulse count onto the counter's freq_in on-board and in loopback self-test.
- Software loads a half-period and a burst length over a valid/ready config port, then issues start and stop commands.
- Output is glitch-free and fully registered, derived from the 50 MHz system clock.

Parameters:
- CLK_HZ, 50000000, system clock frequency (documentation and bench scaling only; no logic depends on it).
- DIV_W, 24, width of the half-period divider.
- BURST_W, 16, width of the burst length and pulse counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- cfg_valid  input  1  config word present.
- cfg_ready  output  1  config accepted this cycle when high with cfg_valid.
- cfg_half_period  input  DIV_W  freq_out high/low phase length in clk cycles; must be at least 1.
- cfg_burst_len  input  BURST_W  number of pulses per run; 0 means continuous.
- start  input  1  single-cycle start command.
- stop  input  1  single-cycle stop command.
- freq_out  output  1  generated waveform.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when a burst completes.
- pulse_count  output  BURST_W  rising edges emitted in the current or last run.
- cfg_err  output  1  one-cycle pulse on a rejected config or start.

Behaviour:
- Reset values: freq_out=0, busy=0, done=0, cfg_err=0, pulse_count=0, cfg_ready=1, state=IDLE. Reset also clears the stored half-period, burst length, cfg_loaded flag and phase counter.
- Reset asserted mid-run: freq_out is 0 on the next cycle. No done pulse is generated.
- States: IDLE, RUN, STOPPING.
- cfg_ready=1 only in IDLE. A config is accepted when cfg_valid and cfg_ready are both high.
  - cfg_half_period=0: config rejected, cfg_err pulses, stored values unchanged.
  - Otherwise: half-period and burst length are stored and cfg_loaded is set.
- cfg_valid outside IDLE: ignored. The sender must hold it until cfg_ready.
- Start in IDLE with cfg_loaded=1, at edge E0:
  - state becomes RUN, freq_out=1, phase counter=0, pulse_count=1 (the first rising edge counts).
  - Latency from start sampled to freq_out high is 1 cycle.
- Start in IDLE with cfg_loaded=0: cfg_err pulses, state stays IDLE.
- Start while busy: ignored.
- RUN phase counting:
  - The phase counter increments each cycle.
  - When counter equals half_period-1, freq_out toggles and the counter returns to 0.
  - Each phase lasts exactly half_period cycles, so the period is 2*half_period cycles.
  - half_period=1 gives clk/2.
- Every 0-to-1 toggle increments pulse_count. The count wraps modulo 2^BURST_W in continuous mode.
- Burst end: with burst_len nonzero and pulse_count equal to burst_len, the falling toggle of that pulse ends the run. On that same edge:
  - freq_out=0, done=1 for one cycle, state=IDLE, busy=0 on the following cycle.
  - No further rising edge is emitted.
- Stop in RUN:
  - If freq_out=0: the next edge gives state IDLE. No new pulse.
  - If freq_out=1: state becomes STOPPING. The current high phase completes at full length, then freq_out falls and state becomes IDLE.
  - A stop never produces a runt pulse and never asserts done.
- Stop in STOPPING or IDLE: no effect.
- Start and stop together in IDLE: stop wins, state stays IDLE.
- Burst end coinciding with stop: treated as burst end, done asserted.
- pulse_count holds its final value after a run and is cleared only by the next accepted start.
- Stored config persists across runs, so start can be repeated without reloading.

Test Plan:
- Reset then idle: hold rst 2 cycles, release -> freq_out=0, busy=0, cfg_ready=1, pulse_count=0 for 20 cycles.
- Burst: load half=5, burst=3, start at E0 ->
  - freq_out high E0-E4, low E5-E9, high E10-E14, low E15-E19, high E20-E24.
  - Falls at E25 with done=1 at E25 only, pulse_count=3, busy=0 from E26.
- Continuous plus stop: load half=2, burst=0, start, then stop on a high-phase cycle -> the high phase completes at 2 cycles, freq_out ends 0, state IDLE, done never asserts. Measured period is 4 cycles.
- Config errors:
  - cfg half=0 -> cfg_err single pulse, cfg_loaded unchanged.
  - start after reset without config -> cfg_err pulse, busy stays 0.
- Busy protection: cfg_valid and start asserted during RUN -> cfg_ready=0, waveform and pulse_count unaffected. A new config is accepted the first cycle after return to IDLE.
- Loopback: half=25, burst=0 driven into digital_frequency_counter -> counter reads 1 MHz. Then reset mid-run -> freq_out=0 the next cycle, no done.
